// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, data and memory-side signals of the
// shared memory port. The arbiter connects through the slave modport; the
// core/memory environment connects through the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Fetch side
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_ack;
  logic [DATA_W-1:0]     if_rdata;
  // Data (load/store) side
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wstrb;
  logic                  d_ack;
  logic [DATA_W-1:0]     d_rdata;
  // Status
  logic                  err;
  logic                  stall;
  // Unified memory side
  logic                  mem_valid;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic                  mem_ready;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
           mem_ready, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, err, stall,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
           mem_ready, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, err, stall,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// data access. Request/grant FSM (IDLE -> GNT_IF/GNT_D -> RESP) with a
// wait-state counter and a bus-timeout abort after WAIT_MAX wait cycles
// (WAIT_MAX = 0 disables the timeout).
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on a
// tie; otherwise data always wins a tie.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int STRB_W = DATA_W / 8;
  // At least one bit so the counter exists even with the timeout disabled.
  localparam int CNT_W  = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, RESP} state_t;
  typedef enum logic {SEL_IF, SEL_D} sel_t;

  state_t              state_q, state_d;
  sel_t                last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic                mem_valid_q, mem_valid_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic tie_to_d;
  logic pick_d;
  logic timeout_hit;
  logic if_ack;
  logic d_ack;

  // On a tie, decide whether data wins.
`ifdef MEM_ARB_RR_EN
  assign tie_to_d = (last_gnt_q == SEL_IF);
`else
  assign tie_to_d = 1'b1;
`endif

  assign pick_d      = bus.d_req & (~bus.if_req | tie_to_d);
  assign timeout_hit = (WAIT_MAX > 0) && (wait_cnt_q == CNT_MAX);

  // Acks are exactly the RESP cycle, routed to whichever side was granted.
  assign if_ack = (state_q == RESP) && (last_gnt_q == SEL_IF);
  assign d_ack  = (state_q == RESP) && (last_gnt_q == SEL_D);

  assign bus.if_ack    = if_ack;
  assign bus.d_ack     = d_ack;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.stall     = (bus.if_req & ~if_ack) | (bus.d_req & ~d_ack);
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

  // Next-state and next-output logic for the request/grant FSM.
  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can infer a latch.
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          mem_valid_d = 1'b1;
          if (pick_d) begin
            state_d     = GNT_D;
            last_gnt_d  = SEL_D;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_we ? bus.d_wdata : '0;
            mem_wstrb_d = bus.d_we ? bus.d_wstrb : '0;
          end else begin
            state_d     = GNT_IF;
            last_gnt_d  = SEL_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end
        end
      end

      GNT_IF, GNT_D: begin
        if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          state_d     = RESP;
          if (state_q == GNT_IF) if_rdata_d = bus.mem_rdata;
          else                   d_rdata_d  = bus.mem_rdata;
        end else if (timeout_hit) begin
          mem_valid_d = 1'b0;
          state_d     = RESP;
          err_d       = 1'b1;
          if (state_q == GNT_IF) if_rdata_d = '0;
          else                   d_rdata_d  = '0;
        end else if (WAIT_MAX > 0) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      RESP: begin
        // No grant here: a request still high during its ack is not re-granted.
        wait_cnt_d = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops mem_valid asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_gnt_q  <= SEL_IF;
      wait_cnt_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      err_q       <= 1'b0;
      // NOTE: the read-data holding registers are reset too, so loads never expose X after reset.
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values.
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      err_q       <= err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-cycle core's one memory port between instruction fetch and data access, which the control unit requests through `mem_read`/`mem_write`. The block runs a request/grant state machine with a wait-state counter and a bus-timeout abort. It stalls the core until each access completes. It sits between the core (fetch unit, load/store path) and the unified memory.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; multiple of 8
- `WAIT_MAX`, 15, maximum cycles `mem_valid` may wait for `mem_ready`; 0 disables the timeout

Clocking: one clock, `clk`. Reset `rst` is asynchronous and active-high.

- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `if_req` in 1: fetch request; held until `if_ack`
- `if_addr` in ADDR_W: fetch address; stable while `if_req`
- `if_ack` out 1: one-cycle fetch completion pulse
- `if_rdata` out DATA_W: fetched word; valid with `if_ack`
- `d_req` in 1: data request (`mem_read | mem_write`); held until `d_ack`
- `d_we` in 1: 1 = store, 0 = load
- `d_addr` in ADDR_W: data address
- `d_wdata` in DATA_W: store data
- `d_wstrb` in DATA_W/8: store byte enables
- `d_ack` out 1: one-cycle data completion pulse
- `d_rdata` out DATA_W: load data; valid with `d_ack`
- `err` out 1: with either ack, marks a timed-out access
- `stall` out 1: `(if_req & ~if_ack) | (d_req & ~d_ack)`, combinational
- `mem_valid` out 1: memory request
- `mem_we` out 1: memory write
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_wstrb` out DATA_W/8: memory byte enables
- `mem_ready` in 1: memory completion; sampled only while `mem_valid`
- `mem_rdata` in DATA_W: memory read data; valid with `mem_ready`

## Operation
- States: IDLE, GNT_IF, GNT_D, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - Request present: pick a winner, register the `mem_*` outputs from the winner's inputs, set `mem_valid=1`, go to GNT_IF or GNT_D.
  - Record the winner in `last_gnt`.
- **GNT_x**
  - `mem_*` outputs stay stable.
  - `mem_ready=1`: capture `mem_rdata` into the winner's rdata register, drop `mem_valid`, go to RESP.
  - `mem_ready=0`: increment `wait_cnt`.
  - Timeout: when `WAIT_MAX>0` and `wait_cnt==WAIT_MAX` with `mem_ready=0`, drop `mem_valid`, zero the rdata register, set `err`, go to RESP.
- **RESP**
  - Pulse the winner's ack (and `err` if set) for one cycle, clear `wait_cnt`, go to IDLE.
  - No grant is made in RESP, so a request still held high during its ack cycle is never re-granted.
- Fetch accesses drive `mem_we=0`, `mem_wstrb=0`, `mem_wdata=0`.
- Loads drive `mem_wstrb=0`.
- Arbitration on a tie (both requests in IDLE) is set by the Configuration section.
- A request arriving mid-access waits; `stall` stays high.
- `d_req` and `if_req` dropping without an ack is a protocol violation. The access in flight still completes, and its ack pulses.
- `rdata` registers hold their value until the next capture.

## Timing
- Reset values:
  - state = IDLE
  - `mem_valid=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `mem_wstrb=0`
  - `if_ack=0`, `d_ack=0`, `err=0`
  - `if_rdata=0`, `d_rdata=0`
  - `wait_cnt=0`, `last_gnt`=fetch
- Reset mid-access drops `mem_valid` immediately (asynchronous). No ack is issued.
- Minimum latency, with `mem_ready` already high:
  - cycle 0: request sampled
  - cycle 1: `mem_valid`
  - cycle 2: ack
- Each memory wait cycle adds one cycle of latency.
- Back-to-back: the next grant occurs in the cycle after the ack (IDLE), so peak throughput is one access per 3 cycles.
- Timeout: `mem_valid` is high for exactly WAIT_MAX+1 cycles, then the ack with `err=1` follows one cycle later.
- `wait_cnt` width is clog2(WAIT_MAX+1). It never wraps because it is cleared in RESP.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on a tie. The grant goes to the requester not in `last_gnt`. Because reset sets `last_gnt`=fetch, the first tie goes to data.
- Undefined: fixed priority. Data always wins a tie.
- Either mode: a lone requester is granted immediately.

## Test plan
- Reset, then `if_req=1` with `if_addr=0x100`, `mem_ready` tied high: `mem_valid` with `mem_addr=0x100`, `mem_we=0` at cycle 1; `if_ack=1` with `if_rdata`=memory word at cycle 2; `stall` low at cycle 3 after the request drops.
- Store `d_addr=0x2000`, `d_wdata=0xDEADBEEF`, `d_wstrb=4'b0011`, with `mem_ready` delayed 3 cycles: `mem_*` stable for 4 cycles, `d_ack` 1 cycle after `mem_ready`, `stall` high throughout.
- Both requests held continuously:
  - with `MEM_ARB_RR_EN`, grants alternate D, IF, D, IF;
  - without it, D is granted first and IF only once `d_req` drops.
- `WAIT_MAX=15`, `mem_ready` stuck low: `mem_valid` high for 16 cycles, then ack with `err=1` and rdata=0; the next access proceeds normally with `err=0`.
- Assert `rst` during GNT_D: `mem_valid` falls the same cycle, no `d_ack`; after release, a held `d_req` is re-granted from IDLE.
